// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag-bit positions for seq_alu.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_REM = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_DBZ   = 2;
    localparam int FLAG_ERR   = 3;
    localparam int FLAG_W     = 4;

endpackage

// File: rtl/alu_iter_unit.sv
// Shared hi/lo shift register running either shift-add multiply or restoring
// divide, one bit per cycle, for exactly WIDTH cycles after start.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;
    mode_e            mode_q;
    logic             run_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // done marks the cycle whose closing edge performs the last iteration, so
    // the caller can register next_hi/next_lo on that same edge.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        next_hi = '0;
        next_lo = '0;
        if (mode_q == MODE_MUL) begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], lo_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            next_hi = diff[WIDTH-1:0];
            next_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = shifted[WIDTH-1:0];
            next_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
        done = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_MUL;
            run_q  <= 1'b0;
        end else if (start) begin
            hi_q   <= '0;
            lo_q   <= a;
            b_q    <= b;
            cnt_q  <= '0;
            mode_q <= mode;
            run_q  <= 1'b1;
        end else if (run_q) begin
            hi_q   <= next_hi;
            lo_q   <= next_lo;
            cnt_q  <= cnt_q + 1'b1;
            run_q  <= !done;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: request handshake, FSM and output registers; MUL/DIV/REM
// with a non-zero divisor are delegated to alu_iter_unit.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             dbz,
    output logic             err
);

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  result_hi_q, result_hi_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              load;
    logic              accept;

    logic              iter_start;
    mode_e             iter_mode;
    logic              iter_done;
    logic [WIDTH-1:0]  iter_hi;
    logic [WIDTH-1:0]  iter_lo;
    logic [WIDTH:0]    add_sum;

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (iter_start),
        .mode    (iter_mode),
        .a       (a),
        .b       (b),
        .done    (iter_done),
        .next_hi (iter_hi),
        .next_lo (iter_lo)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = flags_q[FLAG_CARRY];
    assign zero      = flags_q[FLAG_ZERO];
    assign dbz       = flags_q[FLAG_DBZ];
    assign err       = flags_q[FLAG_ERR];

    // Divide-by-zero and illegal opcodes finish at the accept edge; only
    // iterative ops pass through BUSY.
    always_comb begin
        state_d     = state_q;
        result_d    = '0;
        result_hi_d = '0;
        flags_d     = '0;
        load        = 1'b0;
        accept      = 1'b0;
        iter_start  = 1'b0;
        iter_mode   = MODE_MUL;
        add_sum     = {1'b0, a} + {1'b0, b};
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    load    = 1'b1;
                    state_d = DONE;
                    case (op)
                        OP_ADD: begin
                            result_d            = add_sum[WIDTH-1:0];
                            flags_d[FLAG_CARRY] = add_sum[WIDTH];
                        end
                        OP_SUB: begin
                            result_d            = a - b;
                            flags_d[FLAG_CARRY] = (a < b);
                        end
                        OP_MUL: begin
                            load       = 1'b0;
                            iter_start = 1'b1;
                            iter_mode  = MODE_MUL;
                            state_d    = BUSY;
                        end
                        OP_DIV, OP_REM: begin
                            if (b == '0) begin
                                result_d          = (op == OP_DIV) ? '1 : a;
                                flags_d[FLAG_DBZ] = 1'b1;
                            end else begin
                                load       = 1'b0;
                                iter_start = 1'b1;
                                iter_mode  = MODE_DIV;
                                state_d    = BUSY;
                            end
                        end
                        default: flags_d[FLAG_ERR] = 1'b1;
                    endcase
                end
            end
            BUSY: begin
                if (iter_done) begin
                    load    = 1'b1;
                    state_d = DONE;
                    case (op_q)
                        OP_MUL: begin
                            result_hi_d = iter_hi;
                            result_d    = iter_lo;
                        end
                        OP_DIV:  result_d = iter_lo;
                        default: result_d = iter_hi;
                    endcase
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        flags_d[FLAG_ZERO] = ({result_hi_d, result_d} == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) op_q <= op;
            if (load) begin
                result_q    <= result_d;
                result_hi_q <= result_hi_d;
                flags_q     <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8) using immediate assertions.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       carry;
    logic       zero;
    logic       dbz;
    logic       err;

    int tests  = 0;
    int failed = 0;
    int lat;

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero),
        .dbz       (dbz),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request and counts clock edges after the accept edge until
    // out_valid is seen; optional operand/op/valid churn while waiting.
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input bit churn, output int edges);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 50) begin
            if (churn) begin
                a = 8'($urandom);
                b = 8'($urandom);
                op = 3'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        a = x; b = y; op = o;
    endtask

    task automatic finishOutput();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int exp_lat, input logic [7:0] exp_res,
                               input logic [7:0] exp_hi, input logic exp_c, input logic exp_z,
                               input logic exp_dbz, input logic exp_err);
        chk({tag, "_lat"},    lat,       exp_lat);
        chk({tag, "_valid"},  out_valid, 1);
        chk({tag, "_result"}, result,    exp_res);
        chk({tag, "_hi"},     result_hi, exp_hi);
        chk({tag, "_carry"},  carry,     exp_c);
        chk({tag, "_zero"},   zero,      exp_z);
        chk({tag, "_dbz"},    dbz,       exp_dbz);
        chk({tag, "_err"},    err,       exp_err);
        finishOutput();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result",    {result_hi, result}, 0);
        chk("rst_flags",     {carry, zero, dbz, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(3'b000, 8'd200, 8'd100, 0, lat);
        checkOutput("add_200_100", 0, 8'h2C, 8'h00, 1, 0, 0, 0);
        applyStimulus(3'b000, 8'hFF, 8'hFF, 0, lat);
        checkOutput("add_max", 0, 8'hFE, 8'h00, 1, 0, 0, 0);
        applyStimulus(3'b001, 8'd5, 8'd7, 0, lat);
        checkOutput("sub_5_7", 0, 8'hFE, 8'h00, 1, 0, 0, 0);
        applyStimulus(3'b001, 8'd9, 8'd9, 0, lat);
        checkOutput("sub_9_9", 0, 8'h00, 8'h00, 0, 1, 0, 0);
        applyStimulus(3'b010, 8'hFF, 8'hFF, 1, lat);
        checkOutput("mul_max", 8, 8'h01, 8'hFE, 0, 0, 0, 0);
        applyStimulus(3'b010, 8'd13, 8'd11, 0, lat);
        checkOutput("mul_13_11", 8, 8'h8F, 8'h00, 0, 0, 0, 0);
        applyStimulus(3'b011, 8'd200, 8'd7, 1, lat);
        checkOutput("div_200_7", 8, 8'd28, 8'h00, 0, 0, 0, 0);
        applyStimulus(3'b100, 8'd200, 8'd7, 0, lat);
        checkOutput("rem_200_7", 8, 8'd4, 8'h00, 0, 0, 0, 0);
        applyStimulus(3'b011, 8'd5, 8'd1, 0, lat);
        checkOutput("div_b1", 8, 8'd5, 8'h00, 0, 0, 0, 0);
        applyStimulus(3'b011, 8'd3, 8'd10, 0, lat);
        checkOutput("div_a_lt_b", 8, 8'd0, 8'h00, 0, 1, 0, 0);
        applyStimulus(3'b100, 8'd3, 8'd10, 0, lat);
        checkOutput("rem_a_lt_b", 8, 8'd3, 8'h00, 0, 0, 0, 0);
        applyStimulus(3'b011, 8'd37, 8'd0, 0, lat);
        checkOutput("div_by_0", 0, 8'hFF, 8'h00, 0, 0, 1, 0);
        applyStimulus(3'b100, 8'd37, 8'd0, 0, lat);
        checkOutput("rem_by_0", 0, 8'd37, 8'h00, 0, 0, 1, 0);
        applyStimulus(3'b110, 8'd12, 8'd34, 0, lat);
        checkOutput("illegal_op", 0, 8'h00, 8'h00, 0, 1, 0, 1);

        // Backpressure: result held while out_ready stays low, requests refused.
        applyStimulus(3'b000, 8'd10, 8'd20, 0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid",    out_valid, 1);
            chk("bp_in_ready", in_ready,  0);
            chk("bp_result",   result,    8'd30);
            chk("bp_carry",    carry,     0);
            in_valid = ~in_valid;
            a = 8'($urandom);
            op = 3'b010;
        end
        in_valid = 1'b0;
        finishOutput();
        @(negedge clk);
        chk("bp_after_in_ready",  in_ready,  1);
        chk("bp_after_out_valid", out_valid, 0);
        chk("bp_after_result",    result,    8'd30);

        // Reset in BUSY cycle 3 of a multiply.
        op = 3'b010; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("busy_in_ready",  in_ready,  0);
        chk("busy_out_valid", out_valid, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready",  in_ready,  1);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_result",    {result_hi, result}, 0);
        chk("mrst_flags",     {carry, zero, dbz, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        applyStimulus(3'b000, 8'd1, 8'd1, 0, lat);
        checkOutput("add_after_rst", 0, 8'd2, 8'h00, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
